// File: rtl/alu_share_arbiter.sv
// Round-robin REQ/GNT/DONE arbiter sharing one combinational ALU between two requesters.
// Optional opcode range check (extra ERR output) enabled by defining ALU_ARB_OPRN_CHECK_EN.
module alu_share_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPRN_WIDTH    = 6,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ0,
    input  logic [DATA_WIDTH-1:0] OP1_0,
    input  logic [DATA_WIDTH-1:0] OP2_0,
    input  logic [OPRN_WIDTH-1:0] OPRN_0,
    input  logic                  REQ1,
    input  logic [DATA_WIDTH-1:0] OP1_1,
    input  logic [DATA_WIDTH-1:0] OP2_1,
    input  logic [OPRN_WIDTH-1:0] OPRN_1,
    output logic                  GNT0,
    output logic                  GNT1,
    output logic                  DONE0,
    output logic                  DONE1,
    output logic [DATA_WIDTH-1:0] RES,
    output logic                  RES_ZERO,
    output logic                  BUSY,
`ifdef ALU_ARB_OPRN_CHECK_EN
    output logic                  ERR,
`endif
    output logic [DATA_WIDTH-1:0] ALU_OP1,
    output logic [DATA_WIDTH-1:0] ALU_OP2,
    output logic [OPRN_WIDTH-1:0] ALU_OPRN,
    input  logic [DATA_WIDTH-1:0] ALU_OUT,
    input  logic                  ALU_ZERO
);

    localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int CNT_W      = $clog2(SETTLE_EFF + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_EFF);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   last;
    logic                   win1;
    logic [DATA_WIDTH-1:0]  win_op1;
    logic [DATA_WIDTH-1:0]  win_op2;
    logic [OPRN_WIDTH-1:0]  win_oprn;

`ifdef ALU_ARB_OPRN_CHECK_EN
    function automatic logic oprn_valid(input logic [OPRN_WIDTH-1:0] op);
        return (op >= OPRN_WIDTH'(1)) && (op <= OPRN_WIDTH'(9));
    endfunction
`endif

    // On a tie the requester that was not served last wins.
    always_comb begin
        win1     = REQ1 & (~REQ0 | ~last);
        win_op1  = win1 ? OP1_1  : OP1_0;
        win_op2  = win1 ? OP2_1  : OP2_0;
        win_oprn = win1 ? OPRN_1 : OPRN_0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= S_IDLE;
            cnt      <= '0;
            last     <= 1'b1;
            GNT0     <= 1'b0;
            GNT1     <= 1'b0;
            DONE0    <= 1'b0;
            DONE1    <= 1'b0;
            RES      <= '0;
            RES_ZERO <= 1'b0;
            BUSY     <= 1'b0;
            ALU_OP1  <= '0;
            ALU_OP2  <= '0;
            ALU_OPRN <= '0;
`ifdef ALU_ARB_OPRN_CHECK_EN
            ERR      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (REQ0 || REQ1) begin
                        GNT0 <= ~win1;
                        GNT1 <= win1;
                        BUSY <= 1'b1;
`ifdef ALU_ARB_OPRN_CHECK_EN
                        // Illegal opcodes never reach the ALU; answer immediately with an error.
                        if (!oprn_valid(win_oprn)) begin
                            DONE0    <= ~win1;
                            DONE1    <= win1;
                            RES      <= '0;
                            RES_ZERO <= 1'b0;
                            ERR      <= 1'b1;
                            last     <= win1;
                            state    <= S_DONE;
                        end else
`endif
                        begin
                            ALU_OP1  <= win_op1;
                            ALU_OP2  <= win_op2;
                            ALU_OPRN <= win_oprn;
                            cnt      <= CNT_LOAD;
                            state    <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        RES      <= ALU_OUT;
                        RES_ZERO <= ALU_ZERO;
                        DONE0    <= GNT0;
                        DONE1    <= GNT1;
                        last     <= GNT1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    DONE0 <= 1'b0;
                    DONE1 <= 1'b0;
                    GNT0  <= 1'b0;
                    GNT1  <= 1'b0;
                    BUSY  <= 1'b0;
`ifdef ALU_ARB_OPRN_CHECK_EN
                    ERR   <= 1'b0;
`endif
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: two instances (settle 1 and settle 3) driven by shared requesters,
// each with its own behavioural ALU, checked against a transaction-level round-robin model.
module tb_alu_share_arbiter;

    localparam int DW  = 32;
    localparam int OW  = 6;
    localparam int S_A = 1;
    localparam int S_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n, rst_b;
    logic           req0, req1;
    logic [DW-1:0]  op1_0, op2_0, op1_1, op2_1;
    logic [OW-1:0]  oprn_0, oprn_1;

    logic           gnt0, gnt1, done0, done1, res_zero, busy, alu_zero;
    logic [DW-1:0]  res, alu_op1, alu_op2, alu_out;
    logic [OW-1:0]  alu_oprn;

    logic           b_gnt0, b_gnt1, b_done0, b_done1, b_res_zero, b_busy, b_alu_zero;
    logic [DW-1:0]  b_res, b_alu_op1, b_alu_op2, b_alu_out;
    logic [OW-1:0]  b_alu_oprn;
`ifdef ALU_ARB_OPRN_CHECK_EN
    logic           err, b_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int m_last = 1;

    // Reference ALU: 1 add, 2 sub, 3 mul, 4 and, 5 or, 6 xor, 7 shl, 8 shr, 9 unsigned less-than.
    function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [OW-1:0] op);
        case (op)
            6'd1:    return a + b;
            6'd2:    return a - b;
            6'd3:    return a * b;
            6'd4:    return a & b;
            6'd5:    return a | b;
            6'd6:    return a ^ b;
            6'd7:    return a << b[4:0];
            6'd8:    return a >> b[4:0];
            6'd9:    return (a < b) ? 32'd1 : 32'd0;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_out    = alu_f(alu_op1, alu_op2, alu_oprn);
    assign alu_zero   = (alu_out == '0);
    assign b_alu_out  = alu_f(b_alu_op1, b_alu_op2, b_alu_oprn);
    assign b_alu_zero = (b_alu_out == '0);

    alu_share_arbiter #(.DATA_WIDTH(DW), .OPRN_WIDTH(OW), .SETTLE_CYCLES(S_A)) dut (
        .CLK(clk), .RST(rst_n),
        .REQ0(req0), .OP1_0(op1_0), .OP2_0(op2_0), .OPRN_0(oprn_0),
        .REQ1(req1), .OP1_1(op1_1), .OP2_1(op2_1), .OPRN_1(oprn_1),
        .GNT0(gnt0), .GNT1(gnt1), .DONE0(done0), .DONE1(done1),
        .RES(res), .RES_ZERO(res_zero), .BUSY(busy),
`ifdef ALU_ARB_OPRN_CHECK_EN
        .ERR(err),
`endif
        .ALU_OP1(alu_op1), .ALU_OP2(alu_op2), .ALU_OPRN(alu_oprn),
        .ALU_OUT(alu_out), .ALU_ZERO(alu_zero)
    );

    alu_share_arbiter #(.DATA_WIDTH(DW), .OPRN_WIDTH(OW), .SETTLE_CYCLES(S_B)) dut_b (
        .CLK(clk), .RST(rst_b),
        .REQ0(req0), .OP1_0(op1_0), .OP2_0(op2_0), .OPRN_0(oprn_0),
        .REQ1(req1), .OP1_1(op1_1), .OP2_1(op2_1), .OPRN_1(oprn_1),
        .GNT0(b_gnt0), .GNT1(b_gnt1), .DONE0(b_done0), .DONE1(b_done1),
        .RES(b_res), .RES_ZERO(b_res_zero), .BUSY(b_busy),
`ifdef ALU_ARB_OPRN_CHECK_EN
        .ERR(b_err),
`endif
        .ALU_OP1(b_alu_op1), .ALU_OP2(b_alu_op2), .ALU_OPRN(b_alu_oprn),
        .ALU_OUT(b_alu_out), .ALU_ZERO(b_alu_zero)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_ops(input int who, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [OW-1:0] op);
        if (who == 0) begin op1_0 = a; op2_0 = b; oprn_0 = op; end
        else          begin op1_1 = a; op2_1 = b; oprn_1 = op; end
    endtask

    task automatic rand_ops(input int who);
        logic [DW-1:0] a, b;
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        set_ops(who, a, b, OW'($urandom_range(1, 9)));
    endtask

    task automatic set_req(input int who, input logic v);
        if (who == 0) req0 = v;
        else          req1 = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst_b = 1'b0; req0 = 1'b0; req1 = 1'b0;
        set_ops(0, '0, '0, '0); set_ops(1, '0, '0, '0);
        repeat (2) tick();
        n_cmp++;
        if ({gnt0, gnt1, done0, done1, busy, res_zero, res, alu_op1, alu_op2, alu_oprn} !== '0) begin
            n_bad++;
            $display("FAIL reset_a: gnt=%b%b done=%b%b busy=%b rz=%b res=%0h op1=%0h op2=%0h oprn=%0h, want all 0",
                     gnt0, gnt1, done0, done1, busy, res_zero, res, alu_op1, alu_op2, alu_oprn);
        end
        n_cmp++;
        if ({b_gnt0, b_gnt1, b_done0, b_done1, b_busy, b_res_zero, b_res, b_alu_op1, b_alu_op2, b_alu_oprn} !== '0) begin
            n_bad++;
            $display("FAIL reset_b: outputs nonzero, want all 0");
        end
`ifdef ALU_ARB_OPRN_CHECK_EN
        n_cmp++;
        if ({err, b_err} !== 2'b00) begin n_bad++; $display("FAIL reset_err: got %b%b want 00", err, b_err); end
`endif
        rst_n = 1'b1;
        tick();
        m_last = 1;
    endtask

    task automatic test_single();
        set_ops(0, 32'd15, 32'd3, 6'h01); req0 = 1'b1;
        tick();
        n_cmp++;
        if ({gnt0, gnt1, done0, done1, busy} !== 5'b10001 || alu_op1 !== 32'd15 || alu_oprn !== 6'h01) begin
            n_bad++;
            $display("FAIL single_gnt: gnt/done/busy=%b op1=%0d oprn=%0h want 10001 15 01",
                     {gnt0, gnt1, done0, done1, busy}, alu_op1, alu_oprn);
        end
        tick();
        n_cmp++;
        if ({gnt0, gnt1, done0, done1, busy} !== 5'b10101 || res !== 32'd18 || res_zero !== 1'b0) begin
            n_bad++;
            $display("FAIL single_done: gnt/done/busy=%b res=%0d rz=%b want 10101 18 0",
                     {gnt0, gnt1, done0, done1, busy}, res, res_zero);
        end
        req0 = 1'b0;
        tick();
        n_cmp++;
        if ({gnt0, gnt1, done0, done1, busy} !== 5'b00000 || res !== 32'd18) begin
            n_bad++;
            $display("FAIL single_idle: gnt/done/busy=%b res=%0d want 00000 18", {gnt0, gnt1, done0, done1, busy}, res);
        end
        m_last = 0;
    endtask

    task automatic test_zero();
        set_ops(1, 32'd5, 32'd5, 6'h02); req1 = 1'b1;
        tick();
        n_cmp++;
        if ({gnt0, gnt1, done0, done1, busy} !== 5'b01001) begin
            n_bad++;
            $display("FAIL zero_gnt: gnt/done/busy=%b want 01001", {gnt0, gnt1, done0, done1, busy});
        end
        tick();
        n_cmp++;
        if ({gnt0, gnt1, done0, done1, busy} !== 5'b01011 || res !== 32'd0 || res_zero !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_done: gnt/done/busy=%b res=%0d rz=%b want 01011 0 1",
                     {gnt0, gnt1, done0, done1, busy}, res, res_zero);
        end
        req1 = 1'b0;
        tick();
        m_last = 1;
    endtask

    task automatic test_simultaneous();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        set_ops(0, 32'd7, 32'd5, 6'h03); set_ops(1, 32'd11, 32'd15, 6'h09);
        req0 = 1'b1; req1 = 1'b1;
        tick();
        n_cmp++;
        if ({gnt0, gnt1, done0, done1, busy} !== 5'b10001) begin
            n_bad++;
            $display("FAIL sim_gnt0: gnt/done/busy=%b want 10001", {gnt0, gnt1, done0, done1, busy});
        end
        tick();
        n_cmp++;
        if ({gnt0, gnt1, done0, done1} !== 4'b1010 || res !== 32'd35) begin
            n_bad++;
            $display("FAIL sim_done0: gnt/done=%b res=%0d want 1010 35", {gnt0, gnt1, done0, done1}, res);
        end
        req0 = 1'b0;
        tick();
        n_cmp++;
        if ({gnt0, gnt1, done0, done1, busy} !== 5'b00000) begin
            n_bad++;
            $display("FAIL sim_idle: gnt/done/busy=%b want 00000", {gnt0, gnt1, done0, done1, busy});
        end
        tick();
        n_cmp++;
        if ({gnt0, gnt1, done0, done1, busy} !== 5'b01001) begin
            n_bad++;
            $display("FAIL sim_gnt1: gnt/done/busy=%b want 01001", {gnt0, gnt1, done0, done1, busy});
        end
        tick();
        n_cmp++;
        if ({gnt0, gnt1, done0, done1} !== 4'b0101 || res !== 32'd1 || res_zero !== 1'b0) begin
            n_bad++;
            $display("FAIL sim_done1: gnt/done=%b res=%0d rz=%b want 0101 1 0", {gnt0, gnt1, done0, done1}, res, res_zero);
        end
        req1 = 1'b0;
        tick();
        m_last = 1;
    endtask

    task automatic test_fairness();
        int dones [2];
        int prev_w, exp_w, gcyc, ntx, budget;
        bit in_txn;
        logic [DW-1:0] exp_res;
        dones[0] = 0; dones[1] = 0;
        prev_w = -1; exp_w = 0; gcyc = 0; ntx = 0; budget = 200; in_txn = 1'b0; exp_res = '0;
        rand_ops(0); rand_ops(1);
        req0 = 1'b1; req1 = 1'b1;
        while (ntx < 8 && budget > 0) begin
            tick();
            budget--;
            n_cmp++;
            if ((gnt0 && gnt1) || (done0 && !gnt0) || (done1 && !gnt1)) begin
                n_bad++;
                $display("FAIL fair_excl: gnt=%b%b done=%b%b, want exclusive grant covering done", gnt0, gnt1, done0, done1);
            end
            if (!in_txn && (gnt0 || gnt1)) begin
                in_txn = 1'b1;
                gcyc   = cyc;
                exp_w  = (req0 && req1) ? 1 - m_last : (req0 ? 0 : 1);
                exp_res = (exp_w == 1) ? alu_f(op1_1, op2_1, oprn_1) : alu_f(op1_0, op2_0, oprn_0);
                n_cmp++;
                if ({gnt1, gnt0} !== ((exp_w == 1) ? 2'b10 : 2'b01)) begin
                    n_bad++;
                    $display("FAIL fair_winner: gnt1/gnt0=%b%b want requester %0d", gnt1, gnt0, exp_w);
                end
            end
            if (in_txn && (done0 || done1)) begin
                n_cmp++;
                if ({done1, done0} !== {exp_w == 1, exp_w == 0} || res !== exp_res ||
                    res_zero !== (exp_res == '0) || cyc != gcyc + S_A) begin
                    n_bad++;
                    $display("FAIL fair_done: done1/0=%b%b res=%0h rz=%b lat=%0d want req %0d res=%0h lat=%0d",
                             done1, done0, res, res_zero, cyc - gcyc, exp_w, exp_res, S_A);
                end
                n_cmp++;
                if (exp_w == prev_w) begin
                    n_bad++;
                    $display("FAIL fair_alternate: requester %0d served twice in a row", exp_w);
                end
                m_last = exp_w; prev_w = exp_w; dones[exp_w]++; ntx++; in_txn = 1'b0;
                rand_ops(exp_w);
            end
        end
        n_cmp++;
        if (ntx != 8 || dones[0] != 4 || dones[1] != 4) begin
            n_bad++;
            $display("FAIL fair_count: txns=%0d done0=%0d done1=%0d want 8 4 4", ntx, dones[0], dones[1]);
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_random();
        bit pend [2];
        int exp_w, gcyc, ntx, budget, skip;
        bit in_txn;
        logic [DW-1:0] exp_res;
        pend[0] = 1'b0; pend[1] = 1'b0;
        exp_w = 0; gcyc = 0; ntx = 0; budget = 400; in_txn = 1'b0; exp_res = '0;
        while (ntx < 12 && budget > 0) begin
            tick();
            budget--;
            skip = -1;
            n_cmp++;
            if ((gnt0 && gnt1) || (done0 && !gnt0) || (done1 && !gnt1)) begin
                n_bad++;
                $display("FAIL rand_excl: gnt=%b%b done=%b%b, want exclusive grant covering done", gnt0, gnt1, done0, done1);
            end
            if (!in_txn && (gnt0 || gnt1)) begin
                in_txn = 1'b1;
                gcyc   = cyc;
                exp_w  = (req0 && req1) ? 1 - m_last : (req0 ? 0 : 1);
                exp_res = (exp_w == 1) ? alu_f(op1_1, op2_1, oprn_1) : alu_f(op1_0, op2_0, oprn_0);
                n_cmp++;
                if ({gnt1, gnt0} !== ((exp_w == 1) ? 2'b10 : 2'b01)) begin
                    n_bad++;
                    $display("FAIL rand_winner: gnt1/gnt0=%b%b want requester %0d", gnt1, gnt0, exp_w);
                end
                // Granted requester may withdraw and scramble its operands; the latched copy must win.
                if ($urandom_range(0, 3) == 0) begin
                    rand_ops(exp_w);
                    set_req(exp_w, 1'b0);
                end
            end
            if (in_txn && (done0 || done1)) begin
                n_cmp++;
                if ({done1, done0} !== {exp_w == 1, exp_w == 0} || res !== exp_res ||
                    res_zero !== (exp_res == '0) || cyc != gcyc + S_A) begin
                    n_bad++;
                    $display("FAIL rand_done: done1/0=%b%b res=%0h rz=%b lat=%0d want req %0d res=%0h lat=%0d",
                             done1, done0, res, res_zero, cyc - gcyc, exp_w, exp_res, S_A);
                end
                m_last = exp_w; ntx++; in_txn = 1'b0;
                pend[exp_w] = 1'b0;
                set_req(exp_w, 1'b0);
                skip = exp_w;
            end
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && i != skip && $urandom_range(0, 2) == 0) begin
                    rand_ops(i);
                    set_req(i, 1'b1);
                    pend[i] = 1'b1;
                end
            end
        end
        n_cmp++;
        if (ntx != 12) begin
            n_bad++;
            $display("FAIL rand_count: completed %0d transactions want 12", ntx);
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_exec();
        int g;
        bit seen;
        req0 = 1'b0; req1 = 1'b0;
        rst_b = 1'b1;
        tick();
        set_ops(0, 32'd40, 32'd2, 6'h01); req0 = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin tick(); seen = b_gnt0; end
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL rstx_gnt: GNT0 not seen within 10 cycles, want grant"); end
        repeat (2) tick();
        n_cmp++;
        if ({b_gnt0, b_done0, b_busy} !== 3'b101 || b_alu_op1 !== 32'd40) begin
            n_bad++;
            $display("FAIL rstx_exec: gnt0/done0/busy=%b op1=%0d want 101 40", {b_gnt0, b_done0, b_busy}, b_alu_op1);
        end
        rst_b = 1'b0;
        #1;
        n_cmp++;
        if ({b_gnt0, b_gnt1, b_done0, b_done1, b_busy, b_res_zero, b_res, b_alu_op1, b_alu_op2, b_alu_oprn} !== '0) begin
            n_bad++;
            $display("FAIL rstx_async: gnt=%b%b done=%b%b busy=%b res=%0h op1=%0h, want all 0",
                     b_gnt0, b_gnt1, b_done0, b_done1, b_busy, b_res, b_alu_op1);
        end
        seen = 1'b0;
        repeat (4) begin tick(); if (b_done0 || b_busy) seen = 1'b1; end
        n_cmp++;
        if (seen) begin n_bad++; $display("FAIL rstx_nodone: DONE0/BUSY seen=1 while reset held, want 0"); end
        req0 = 1'b0;
        tick();
        rst_b = 1'b1;
        tick();
        set_ops(0, 32'd100, 32'd23, 6'h02); req0 = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin tick(); seen = b_gnt0; end
        g = cyc;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin tick(); seen = b_done0; end
        n_cmp++;
        if (!seen || cyc != g + S_B || b_res !== 32'd77 || b_res_zero !== 1'b0) begin
            n_bad++;
            $display("FAIL rstx_after: done=%b lat=%0d res=%0d rz=%b want 1 %0d 77 0", seen, cyc - g, b_res, b_res_zero, S_B);
        end
        req0 = 1'b0;
        repeat (4) tick();
        m_last = 0;
    endtask

    task automatic test_oprn_check();
        set_ops(0, 32'd12, 32'd3, 6'h05); req0 = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (done0 !== 1'b1 || res !== 32'd15 || alu_oprn !== 6'h05) begin
            n_bad++;
            $display("FAIL opc_valid: done0=%b res=%0d oprn=%0h want 1 15 05", done0, res, alu_oprn);
        end
        req0 = 1'b0;
        tick();
        set_ops(0, 32'd6, 32'd3, 6'h0F); req0 = 1'b1;
        tick();
`ifdef ALU_ARB_OPRN_CHECK_EN
        n_cmp++;
        if ({gnt0, gnt1, done0, done1, busy} !== 5'b10101 || err !== 1'b1 || res !== '0 || res_zero !== 1'b0 ||
            alu_oprn !== 6'h05 || alu_op1 !== 32'd12) begin
            n_bad++;
            $display("FAIL opc_reject: gnt/done/busy=%b err=%b res=%0d rz=%b oprn=%0h op1=%0d want 10101 1 0 0 05 12",
                     {gnt0, gnt1, done0, done1, busy}, err, res, res_zero, alu_oprn, alu_op1);
        end
        req0 = 1'b0;
        tick();
        n_cmp++;
        if ({gnt0, gnt1, done0, done1, busy, err} !== 6'b000000) begin
            n_bad++;
            $display("FAIL opc_clear: gnt/done/busy/err=%b want 000000", {gnt0, gnt1, done0, done1, busy, err});
        end
`else
        n_cmp++;
        if ({gnt0, gnt1, done0, done1, busy} !== 5'b10001 || alu_oprn !== 6'h0F || alu_op1 !== 32'd6) begin
            n_bad++;
            $display("FAIL opc_issue: gnt/done/busy=%b oprn=%0h op1=%0d want 10001 0f 6",
                     {gnt0, gnt1, done0, done1, busy}, alu_oprn, alu_op1);
        end
        tick();
        n_cmp++;
        if (done0 !== 1'b1 || res !== alu_f(32'd6, 32'd3, 6'h0F) || res_zero !== 1'b0) begin
            n_bad++;
            $display("FAIL opc_result: done0=%b res=%0d rz=%b want 1 %0d 0", done0, res, res_zero, alu_f(32'd6, 32'd3, 6'h0F));
        end
        req0 = 1'b0;
        tick();
`endif
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_zero();
        test_simultaneous();
        test_fairness();
        test_random();
        test_reset_mid_exec();
        test_oprn_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (OUT, ZERO, OP1, OP2, OPRN) between two requesters, e.g. the main datapath and an address/branch-compare unit.
- Uses a REQ/GNT/DONE handshake with round-robin arbitration.
- Holds the ALU inputs stable for a programmable settle time, then registers the result and zero flag.
- Sits between the requesters and the single ALU instance in the processor top level.

Parameters:
DATA_WIDTH, 32, operand/result width (matches the codebase data width)
OPRN_WIDTH, 6, ALU operation code width
SETTLE_CYCLES, 1, cycles ALU inputs are held before capture; value 0 is treated as 1

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-low reset
REQ0  input  1  requester 0 request; held high with operands stable until DONE0
OP1_0  input  DATA_WIDTH  requester 0 operand 1
OP2_0  input  DATA_WIDTH  requester 0 operand 2
OPRN_0  input  OPRN_WIDTH  requester 0 operation
REQ1  input  1  requester 1 request
OP1_1  input  DATA_WIDTH  requester 1 operand 1
OP2_1  input  DATA_WIDTH  requester 1 operand 2
OPRN_1  input  OPRN_WIDTH  requester 1 operation
GNT0  output  1  high while requester 0 owns the ALU (EXEC and DONE states)
GNT1  output  1  high while requester 1 owns the ALU
DONE0  output  1  one-cycle pulse: RES/RES_ZERO valid for requester 0
DONE1  output  1  one-cycle pulse: RES/RES_ZERO valid for requester 1
RES  output  DATA_WIDTH  registered ALU result, held until next capture
RES_ZERO  output  1  registered ALU zero flag
BUSY  output  1  high in any state other than IDLE
ALU_OP1  output  DATA_WIDTH  to ALU OP1
ALU_OP2  output  DATA_WIDTH  to ALU OP2
ALU_OPRN  output  OPRN_WIDTH  to ALU OPRN
ALU_OUT  input  DATA_WIDTH  from ALU OUT
ALU_ZERO  input  1  from ALU ZERO

Behaviour:
- Reset (RST low, asynchronous):
  - All outputs are 0; state is IDLE; settle counter is 0.
  - Round-robin pointer LAST=1, so requester 0 wins the first tie.
  - Reset during EXEC or DONE aborts the operation: no DONE pulse, no RES update.
- FSM states: IDLE, EXEC, DONE. All outputs are registered.
- IDLE:
  - On a rising edge with any REQ high, select the winner. If only one is requesting, that one wins. If both, the winner is the requester not equal to LAST.
  - Latch the winner's OP1/OP2/OPRN into ALU_OP1/ALU_OP2/ALU_OPRN.
  - Set GNTx=1 and load the counter with max(SETTLE_CYCLES,1); go to EXEC.
  - With no request, stay in IDLE; ALU_* hold their last values.
- EXEC:
  - Decrement the counter each edge.
  - On the edge where the counter reaches 0: RES<=ALU_OUT, RES_ZERO<=ALU_ZERO, DONEx<=1, LAST<=x, go to DONE.
  - Requester inputs are ignored in EXEC; operands are taken only from the latched copies.
- DONE:
  - Lasts one cycle, with DONEx and GNTx high.
  - At the next edge: DONEx<=0, GNTx<=0, go to IDLE.
  - The requester drops REQ on the edge where it samples DONE. REQ seen high again in IDLE is a new request.
- Latency: REQ sampled at edge k -> GNT high in cycle k+1 -> DONE high in cycle k+SETTLE_CYCLES+1.
- Back-to-back operation: with both REQ held continuously, grants alternate 0,1,0,1. Each transaction occupies SETTLE_CYCLES+1 cycles plus one IDLE cycle.
- A requester dropping REQ while granted has no effect; the transaction completes and DONE still pulses.
- GNT0 and GNT1 are never high simultaneously. DONEx is never high without GNTx.
- Arithmetic is performed entirely by the ALU. The arbiter performs no width conversion; RES is exactly ALU_OUT.

Optional Feature:
- Macro: ALU_ARB_OPRN_CHECK_EN.
- When defined:
  - An extra output ERR (1 bit, reset 0) is present.
  - In IDLE, a winning request with OPRN outside 0x01..0x09 is not issued to the ALU; ALU_* are unchanged.
  - State goes directly to DONE with RES=0, RES_ZERO=0, DONEx=1, ERR=1 for that cycle. LAST updates as normal.
- When undefined:
  - There is no ERR port.
  - Every opcode is issued unchanged and the result is whatever the ALU returns.

Test Plan:
1. Reset then single request: REQ0=1, OP1_0=15, OP2_0=3, OPRN_0=0x01, SETTLE_CYCLES=1 -> GNT0 in the cycle after sampling; DONE0 one cycle later with RES=18, RES_ZERO=0; BUSY low afterwards.
2. Zero flag: REQ1 with 5, 5, 0x02 -> DONE1 with RES=0, RES_ZERO=1.
3. Simultaneous requests after reset: REQ0 (7,5,0x03) and REQ1 (11,15,0x09) both held -> requester 0 served first (RES=35), then requester 1 (RES=1, RES_ZERO=0); GNTs never overlap.
4. Fairness: both REQ held high for 8 transactions -> grants strictly alternate; DONE count 4 each.
5. Reset mid-EXEC with SETTLE_CYCLES=3: assert RST low two cycles after GNT0 -> all outputs 0 immediately, no DONE0; a new REQ0 after release completes normally.
6. With ALU_ARB_OPRN_CHECK_EN: REQ0 with OPRN=0x0F -> DONE0 and ERR high in the same cycle with RES=0; ALU_OPRN keeps its previous value. Without the macro, the same opcode is issued to the ALU.
